// File: rtl/data_mem_responder.sv
// Multi-cycle word-organised data memory behind the MEM stage, fixed LATENCY.
// Optional address checking: define DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int SIZE    = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_o
);

    localparam int AW = $clog2(SIZE);
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          cap_we;
    logic          cap_err;
    logic [AW-1:0] cap_idx;
    logic [31:0]   cap_wdata;
    logic [31:0]   mem [SIZE];

    logic          accept;
    logic          fire;
    logic          req_err;
    logic          a_we;
    logic          a_err;
    logic [AW-1:0] a_idx;
    logic [31:0]   a_wdata;
    logic          unused_addr;

    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(SIZE * 4));
`else
    assign req_err = 1'b0;
`endif

    assign accept    = (state == IDLE) && req_valid;
    assign req_ready = !rst && (state == IDLE);
    assign stall_o   = !rst && (accept || (state == BUSY));

    // With LATENCY=1 the access happens on the accept edge using the live request.
    always_comb begin
        fire    = 1'b0;
        a_we    = cap_we;
        a_err   = cap_err;
        a_idx   = cap_idx;
        a_wdata = cap_wdata;
        if (LATENCY == 1) begin
            fire    = accept;
            a_we    = req_we;
            a_err   = req_err;
            a_idx   = req_addr[AW+1:2];
            a_wdata = req_wdata;
        end else begin
            fire = (state == BUSY) && (cnt == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_we     <= 1'b0;
            cap_err    <= 1'b0;
            cap_idx    <= '0;
            cap_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_err   <= req_err;
                        cap_idx   <= req_addr[AW+1:2];
                        cap_wdata <= req_wdata;
                        cnt       <= CW'(LATENCY - 1);
                        state     <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase

            // Data and error are registered on the edge entering RESP.
            if (fire) begin
                resp_valid <= 1'b1;
                resp_err   <= a_err;
                resp_rdata <= (a_we || a_err) ? 32'h0 : mem[a_idx];
                if (a_we && !a_err) begin
                    mem[a_idx] <= a_wdata;
                end
            end else begin
                resp_valid <= 1'b0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: transaction-level model plus directed cases.
// Expectations follow DMEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_data_mem_responder;

    localparam int SIZE = 32;
    localparam int LAT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, stall_o;
    logic [31:0] resp_rdata;

    logic        sv = 1'b0;
    logic [31:0] sa = '0;
    logic        l1_ready, l1_valid, l1_err, l1_stall;
    logic [31:0] l1_rdata;
    logic        l4_ready, l4_valid, l4_err, l4_stall;
    logic [31:0] l4_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.SIZE(SIZE), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .stall_o(stall_o)
    );

    data_mem_responder #(.SIZE(SIZE), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(sv), .req_we(1'b0),
        .req_addr(sa), .req_wdata(32'h0), .req_ready(l1_ready),
        .resp_valid(l1_valid), .resp_rdata(l1_rdata),
        .resp_err(l1_err), .stall_o(l1_stall)
    );

    data_mem_responder #(.SIZE(SIZE), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req_valid(sv), .req_we(1'b0),
        .req_addr(sa), .req_wdata(32'h0), .req_ready(l4_ready),
        .resp_valid(l4_valid), .resp_rdata(l4_rdata),
        .resp_err(l4_err), .stall_o(l4_stall)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        bit en;
        logic bad;
`ifdef DMEM_ALIGN_CHECK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        bad = (a[1:0] != 2'b00) || (a >= 32'(SIZE * 4));
        return en && bad;
    endfunction

    // Transaction model: one outstanding access, answered LAT cycles after acceptance.
    logic [31:0] mmem [SIZE];
    bit          pend = 1'b0;
    int          acc_cyc = 0;
    int          cyc = 0;
    logic        p_we = 1'b0;
    logic        p_err = 1'b0;
    int          p_idx = 0;
    logic [31:0] p_wdata = '0;
    logic [31:0] p_rdata = '0;
    logic [31:0] shown = '0;

    initial begin
        for (int i = 0; i < SIZE; i++) mmem[i] = '0;
    end

    always @(negedge clk) begin
        logic e_valid, e_ready, e_stall, e_err;
        e_valid = pend && (cyc - acc_cyc == LAT);
        e_ready = !rst && !pend;
        e_stall = !rst && ((!pend && req_valid) || (pend && (cyc - acc_cyc < LAT)));
        if (e_valid) shown = p_rdata;
        e_err = e_valid && p_err;
        check("ready", req_ready, e_ready);
        check("resp_valid", resp_valid, e_valid);
        check("stall", stall_o, e_stall);
        check("rdata", resp_rdata, shown);
        check("err", resp_err, e_err);
        if (rst) begin
            pend  = 1'b0;
            shown = '0;
            for (int i = 0; i < SIZE; i++) mmem[i] = '0;
        end else if (!pend && req_valid) begin
            pend    = 1'b1;
            acc_cyc = cyc;
            p_we    = req_we;
            p_err   = addr_err(req_addr);
            p_idx   = int'((req_addr >> 2) % SIZE);
            p_wdata = req_wdata;
            p_rdata = (p_we || p_err) ? 32'h0 : mmem[p_idx];
        end else if (e_valid) begin
            if (p_we && !p_err) mmem[p_idx] = p_wdata;
            pend = 1'b0;
        end
        cyc++;
    end

    task automatic access(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic e, output int lat,
                          output logic [7:0] st);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        lat = -1;
        rd  = '0;
        e   = 1'b0;
        st  = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 8) st[k] = stall_o;
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                e   = resp_err;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        logic [7:0]  st;
        int          n, k1, k4, r;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);

        @(posedge clk); #1;
        sv = 1'b1;
        sa = 32'h4;
        k1 = -1;
        k4 = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (l1_valid && k1 < 0) k1 = k;
            if (l4_valid && k4 < 0) k4 = k;
        end
        @(posedge clk); #1 sv = 1'b0;
        check("lat1", k1, 1);
        check("lat4", k4, 4);

        access(1'b0, 32'h4, 32'h0, rd, e, lat, st);
        check("load_fresh", rd, 32'h0);
        check("load_fresh_lat", lat, 2);

        access(1'b1, 32'h8, 32'hDEADBEEF, rd, e, lat, st);
        check("store_lat", lat, 2);
        check("store_rdata", rd, 32'h0);
        check("store_stall_t0", st[0], 1);
        check("store_stall_t1", st[1], 1);
        check("store_stall_t2", st[2], 0);
        access(1'b0, 32'h8, 32'h0, rd, e, lat, st);
        check("load_back", rd, 32'hDEADBEEF);
        check("load_back_lat", lat, 2);

        @(posedge clk); #1;
        req_valid = 1'b1;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                n++;
                check("cont_phase", k % (LAT + 1), LAT);
            end
            @(posedge clk); #1;
            req_we    = ~req_we;
            req_addr  = $urandom_range(0, SIZE - 1) * 4;
            req_wdata = $urandom;
        end
        req_valid = 1'b0;
        check("cont_count", n, 10);

        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hCAFE0001;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", req_ready, 0);
        check("abort_stall", stall_o, 0);
        n = resp_valid ? 1 : 0;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        check("abort_noresp", n, 0);
        access(1'b0, 32'h10, 32'h0, rd, e, lat, st);
        check("abort_load", rd, 32'h0);

        do_reset();
        access(1'b1, 32'h80, 32'h11, rd, e, lat, st);
`ifdef DMEM_ALIGN_CHECK_EN
        check("wrap_store_err", e, 1);
`else
        check("wrap_store_err", e, 0);
`endif
        check("wrap_store_lat", lat, 2);
        access(1'b0, 32'h0, 32'h0, rd, e, lat, st);
`ifdef DMEM_ALIGN_CHECK_EN
        check("wrap_load0", rd, 32'h0);
`else
        check("wrap_load0", rd, 32'h11);
`endif
        access(1'b0, 32'h2, 32'h0, rd, e, lat, st);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_load_err", e, 1);
        check("mis_load_rdata", rd, 32'h0);
`else
        check("mis_load_err", e, 0);
        check("mis_load_rdata", rd, 32'h11);
`endif
        check("mis_load_lat", lat, 2);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_we    = 1'($urandom);
            req_wdata = $urandom;
            r = $urandom_range(0, 3);
            if (r == 0) req_addr = $urandom;
            else if (r == 1) req_addr = $urandom_range(0, SIZE * 2 - 1) * 4 + $urandom_range(0, 3);
            else req_addr = $urandom_range(0, SIZE * 2 - 1) * 4;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
